// File: rtl/toggle_meter_pkg.sv
// Shared types for the toggle interval meter.
// With TOGGLE_METER_TIMESTAMP_EN defined, every entry also carries a 32-bit closing-edge timestamp.
package toggle_meter_pkg;

  localparam int TS_W = 32;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_e;

  // Width-independent part of a FIFO entry; the interval field is added by the top,
  // whose CNT_W parameter sets its width.
  typedef struct packed {
`ifdef TOGGLE_METER_TIMESTAMP_EN
    logic [TS_W-1:0] timestamp;
`endif
    logic            level;
    logic            sat;
  } entry_tag_t;

endpackage

// File: rtl/toggle_meter_fifo.sv
// Synchronous FIFO for measured intervals; a push into a full FIFO is accepted only
// when a pop happens in the same cycle, otherwise it is reported through `dropped`.
module toggle_meter_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic push,
  input  logic pop,
  input  T     din,
  output T     dout,
  output logic full,
  output logic empty,
  output logic dropped
);
  localparam int AW = $clog2(DEPTH);

  T           mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic       wr_en, rd_en;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en   = pop & ~empty;
  assign wr_en   = push & (~full | rd_en);
  assign dropped = push & full & ~rd_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout = empty ? T'('0) : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/toggle_interval_meter.sv
// Measures clk cycles between successive toggles of an asynchronous input and queues them.
// Optional TOGGLE_METER_TIMESTAMP_EN adds a free-running cycle counter and out_timestamp.
module toggle_interval_meter
  import toggle_meter_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_interval,
  output logic             out_level,
  output logic             out_sat,
`ifdef TOGGLE_METER_TIMESTAMP_EN
  output logic [TS_W-1:0]  out_timestamp,
`endif
  output logic             overflow
);

  typedef struct packed {
    logic [CNT_W-1:0] interval;
    entry_tag_t       tag;
  } entry_t;

  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_sync, s_prev, edge_p;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   push, pop, full, empty, dropped;
  entry_t                 wr_entry, head;

  // Synchronizer runs through clr so an edge right after clr release is still seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      s_prev <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      s_prev <= s_sync;
    end
  end

  assign s_sync = sync_q[SYNC_STAGES-1];
  assign edge_p = s_sync ^ s_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    if (clr) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (edge_p) begin
            state_d = MEASURE;
            cnt_d   = CNT_W'(1);
          end
        end
        MEASURE: begin
          if (edge_p) begin
            push  = 1'b1;
            cnt_d = CNT_W'(1);
          end else if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef TOGGLE_METER_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      ts_q <= '0;
    else if (clr) ts_q <= '0;
    else          ts_q <= ts_q + TS_W'(1);
  end

  assign wr_entry.tag.timestamp = ts_q;
  assign out_timestamp          = head.tag.timestamp;
`endif

  assign wr_entry.interval = cnt_q;
  assign wr_entry.tag.level = s_sync;
  assign wr_entry.tag.sat   = (cnt_q == CNT_SAT);

  assign pop = out_valid & out_ready & ~clr;

  toggle_meter_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .push    (push),
    .pop     (pop),
    .din     (wr_entry),
    .dout    (head),
    .full    (full),
    .empty   (empty),
    .dropped (dropped)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          overflow <= 1'b0;
    else if (clr)     overflow <= 1'b0;
    else if (dropped) overflow <= 1'b1;
  end

  assign out_valid    = ~empty;
  assign out_interval = head.interval;
  assign out_level    = head.tag.level;
  assign out_sat      = head.tag.sat;

endmodule

// File: tb/tb_toggle_interval_meter.sv
// Scoreboard bench for toggle_interval_meter: toggle-time reference model plus decoupled monitor.
module tb_toggle_interval_meter;
  localparam int CNT_W = 6;
  localparam int DEPTH = 4;
  localparam int SS    = 2;
  localparam int LAT   = SS + 1;
  localparam int SATV  = (1 << CNT_W) - 1;

  logic             clk = 1'b0, rst = 1'b1, sig_in = 1'b0, clr = 1'b0, out_ready = 1'b0;
  logic             out_valid, out_level, out_sat, overflow;
  logic [CNT_W-1:0] out_interval;
`ifdef TOGGLE_METER_TIMESTAMP_EN
  logic [31:0]      out_timestamp;
`endif

  toggle_interval_meter #(.CNT_W(CNT_W), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
    .clk          (clk),
    .rst          (rst),
    .sig_in       (sig_in),
    .clr          (clr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_interval (out_interval),
    .out_level    (out_level),
    .out_sat      (out_sat),
`ifdef TOGGLE_METER_TIMESTAMP_EN
    .out_timestamp(out_timestamp),
`endif
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; bit lvl; } tog_t;
  typedef struct { int iv; bit lvl; bit sat; int unsigned ts; } exp_t;

  tog_t        tog_q[$];
  exp_t        sb[$];
  int          cyc = 0, occ = 0, last_edge = 0, n_pops = 0;
  bit          have_ref = 0, m_ovf = 0, rnd_rdy = 0;
  int unsigned m_ts = 0;
  int          n_tests = 0, n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    tog_q.delete(); sb.delete();
    occ = 0; have_ref = 0; m_ovf = 0; m_ts = 0;
  endtask

  // Reference model: an edge is seen LAT cycles after the toggle; the interval is the
  // distance between consecutive seen edges, clipped at the counter maximum.
  bit   m_e, m_pop;
  tog_t m_t;
  int   m_d;
  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      m_e = 0;
      if (tog_q.size() > 0 && tog_q[0].cyc + LAT == cyc) begin
        m_t = tog_q.pop_front();
        m_e = 1;
      end
      m_pop = (occ > 0) && out_ready && !clr;
      if (clr) begin
        have_ref = 0; occ = 0; m_ovf = 0; sb.delete();
      end else begin
        if (m_e) begin
          if (have_ref) begin
            m_d = cyc - last_edge;
            if (occ == DEPTH && !m_pop) m_ovf = 1;
            else begin
              sb.push_back('{(m_d > SATV) ? SATV : m_d, m_t.lvl, (m_d >= SATV), m_ts});
              occ++;
            end
          end
          have_ref  = 1;
          last_edge = cyc;
        end
        if (m_pop) occ--;
      end
      m_ts = clr ? 0 : m_ts + 1;
    end
  end

  // Monitor: compares whatever the DUT presents against the scoreboard head.
  exp_t x;
  always @(negedge clk) begin
    if (!rst) begin
      check("valid", out_valid, occ > 0);
      check("overflow", overflow, m_ovf);
      if (occ == 0) begin
        check("empty_interval", out_interval, 0);
        check("empty_level", out_level, 0);
        check("empty_sat", out_sat, 0);
      end else if (out_valid && out_ready && !clr) begin
        if (sb.size() == 0) check("sb_underflow", 1, 0);
        else begin
          x = sb.pop_front();
          n_pops++;
          check("interval", out_interval, x.iv);
          check("level", out_level, x.lvl);
          check("sat", out_sat, x.sat);
`ifdef TOGGLE_METER_TIMESTAMP_EN
          check("timestamp", out_timestamp, x.ts);
`endif
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk); #2;
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic tog();
    sig_in = ~sig_in;
    tog_q.push_back('{cyc, sig_in});
  endtask

  task automatic clr_pulse();
    clr = 1'b1; tick(); clr = 1'b0;
  endtask

  task automatic do_rst();
    if (sig_in) tog();
    tick(LAT + 2);
    #1 rst = 1'b1; model_reset();
    #1 check("rst_async_valid", out_valid, 0);
    check("rst_async_ovf", overflow, 0);
    #2 rst = 1'b0;
  endtask

  int p0, gap;
  initial begin
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("reset_valid", out_valid, 0);
    check("reset_interval", out_interval, 0);
    check("reset_level", out_level, 0);
    check("reset_sat", out_sat, 0);
    check("reset_overflow", overflow, 0);

    // Three toggles ten cycles apart: two entries of 10.
    out_ready = 1'b1; tick();
    p0 = n_pops;
    tog(); tick(10); tog(); tick(10); tog(); tick(15);
    check("basic_pops", n_pops - p0, 2);

    // Overflow: five entries into a depth-4 FIFO with no consumer.
    out_ready = 1'b0; clr_pulse();
    for (int i = 0; i < 6; i++) begin tog(); tick(5); end
    tick(5);
    check("ovf_set", overflow, 1);
    check("ovf_full_valid", out_valid, 1);
    p0 = n_pops; out_ready = 1'b1; tick(8);
    check("ovf_drain_pops", n_pops - p0, 4);
    check("ovf_drained", out_valid, 0);

    // Saturation then a short interval.
    tog(); tick(70); tog(); tick(5); tog(); tick(10);

    // Full FIFO with push and pop landing on the same cycle.
    out_ready = 1'b0; clr_pulse();
    for (int i = 0; i < 5; i++) begin tog(); tick(3); end
    tick(6);
    tog(); tick(2); out_ready = 1'b1; tick(); out_ready = 1'b0;
    tick(3);
    check("pushpop_no_ovf", overflow, 0);
    p0 = n_pops; out_ready = 1'b1; tick(8);
    check("pushpop_pops", n_pops - p0, 4);

    // Asynchronous reset mid-measurement with queued entries.
    out_ready = 1'b0;
    tog(); tick(4); tog(); tick(6);
    do_rst();
    tick(); tog(); tick(8);
    check("post_rst_idle", out_valid, 0);

    // Clear with overflow set and entries queued.
    for (int i = 0; i < 6; i++) begin tog(); tick(3); end
    tick(4);
    check("pre_clr_ovf", overflow, 1);
    clr_pulse(); #1;
    check("post_clr_valid", out_valid, 0);
    check("post_clr_ovf", overflow, 0);
    tick(); tog(); tick(8);
    check("post_clr_idle", out_valid, 0);

    // Randomized toggles, consumer stalls and occasional clears.
    rnd_rdy = 1'b1;
    repeat (300) begin
      gap = ($urandom_range(0, 9) == 0) ? $urandom_range(50, 90) : $urandom_range(1, 20);
      tog(); tick(gap);
      if ($urandom_range(0, 40) == 0) clr_pulse();
    end
    rnd_rdy = 1'b0; out_ready = 1'b1;
    tick(LAT + DEPTH + 4);
    check("final_sb_empty", sb.size(), 0);
    check("final_valid", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
